// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the unified memory-bus arbiter:
//   - memory command encodings (MEM_NONE / MEM_LW / MEM_SW)
//   - the architectural no-op instruction substituted on an aborted fetch
//   - arbiter FSM state encoding
//   - the latched bus transfer descriptor
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Memory command encodings carried on dm_cmd / bus_cmd.
  localparam logic [3:0] MEM_NONE = 4'h0;
  localparam logic [3:0] MEM_LW   = 4'h2;
  localparam logic [3:0] MEM_SW   = 4'hA;

  // addi x0, x0, 0 -- harmless instruction handed to IF when a fetch is aborted.
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  // Arbiter FSM states.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_FETCH = 2'd1;
  localparam arb_state_t ARB_DATA  = 2'd2;

  // Everything that is captured at grant time and held on the bus until the
  // transaction retires.
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_xfer_t;

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Wait-cycle counter for the arbiter watchdog.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous reset, active-low
//   clr_i   synchronous clear (has priority over en_i)
//   en_i    count enable, one increment per enabled cycle
//   tc_o    terminal count: counter equals TERM-1
// -----------------------------------------------------------------------------
module mem_arb_timer #(
  parameter int CNT_W = 8,
  parameter int TERM  = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(TERM - 1));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory bus between instruction fetch and MEM-stage
// data access. Data has priority; a starvation counter forces a fetch after
// STARVE_LIMIT consecutive data grants with fetch pending. A watchdog aborts a
// transaction after TIMEOUT cycles without bus_ack and acks the requester with
// substitute data.
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_inst/if_ack      fetch side, ack is a 1-cycle pulse
//   dm_cmd/dm_addr/dm_din -> dm_dout/dm_ack   data side
//   bus_req/bus_cmd/bus_addr/bus_wdata    registered bus request
//   bus_rdata/bus_ack                     bus response
//   stall_if/stall_mem                    pipeline stall levels
//   err/err_src                           timeout pulse and its source (1=data)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_ack,
  input  logic [3:0]  dm_cmd,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_din,
  output logic [31:0] dm_dout,
  output logic        dm_ack,
  output logic        bus_req,
  output logic [3:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output logic        err_src
);

  arb_state_t       state_q, state_d;
  bus_xfer_t        xfer_q, xfer_d;
  logic             bus_req_q, bus_req_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             err_q, err_d;
  logic             err_src_q, err_src_d;
  // Substitute-ack flags: the cycle after a timeout, the aborted requester
  // sees its ack while the FSM is already back in IDLE.
  logic             abort_if_q, abort_if_d;
  logic             abort_dm_q, abort_dm_d;

  logic dm_req, busy, fetch_done, data_done, wait_tc, timeout;
  logic starved, can_grant, grant_data, grant_fetch;

  assign dm_req     = (dm_cmd != MEM_NONE);
  assign busy       = (state_q != ARB_IDLE);
  assign fetch_done = (state_q == ARB_FETCH) && bus_ack;
  assign data_done  = (state_q == ARB_DATA) && bus_ack;
  assign timeout    = busy && !bus_ack && wait_tc;
  assign starved    = if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  // During a substitute-ack cycle the requester still presents the request it
  // is being acked for; granting it again would replay the access.
  assign can_grant   = (state_q == ARB_IDLE) && !abort_if_q && !abort_dm_q;
  assign grant_data  = can_grant && dm_req && !starved;
  assign grant_fetch = can_grant && if_req && !grant_data;

  mem_arb_timer #(
    .CNT_W (CNT_W),
    .TERM  (TIMEOUT)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (grant_data || grant_fetch),
    .en_i   (busy && !bus_ack),
    .tc_o   (wait_tc)
  );

  // NOTE: every variable assigned in this block gets its hold value first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    bus_req_d    = bus_req_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = timeout;
    err_src_d    = timeout ? (state_q == ARB_DATA) : err_src_q;
    abort_if_d   = timeout && (state_q == ARB_FETCH);
    abort_dm_d   = timeout && (state_q == ARB_DATA);

    if (grant_data) begin
      state_d   = ARB_DATA;
      bus_req_d = 1'b1;
      xfer_d    = '{cmd: dm_cmd, addr: dm_addr, wdata: dm_din};
    end else if (grant_fetch) begin
      state_d   = ARB_FETCH;
      bus_req_d = 1'b1;
      xfer_d    = '{cmd: MEM_LW, addr: if_addr, wdata: 32'h0};
    end

    if (busy && (bus_ack || timeout)) begin
      state_d    = ARB_IDLE;
      bus_req_d  = 1'b0;
      xfer_d.cmd = MEM_NONE;
    end

    // Counts data grants that overtook a pending fetch; saturates at the limit.
    if (!if_req || grant_fetch)
      starve_cnt_d = '0;
    else if (grant_data && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      xfer_q       <= '{cmd: MEM_NONE, addr: 32'h0, wdata: 32'h0};
      bus_req_q    <= 1'b0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
      err_src_q    <= 1'b0;
      abort_if_q   <= 1'b0;
      abort_dm_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      xfer_q       <= xfer_d;
      bus_req_q    <= bus_req_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      err_src_q    <= err_src_d;
      abort_if_q   <= abort_if_d;
      abort_dm_q   <= abort_dm_d;
    end
  end

  // Acks and read data are combinational so the pipeline advances in the
  // very cycle the bus answers.
  assign if_ack    = fetch_done || abort_if_q;
  assign if_inst   = fetch_done ? bus_rdata : NOOP_INST;
  assign dm_ack    = data_done || abort_dm_q;
  assign dm_dout   = data_done ? bus_rdata : 32'h0;
  assign stall_if  = if_req && !if_ack;
  assign stall_mem = dm_req && !dm_ack;

  assign bus_req   = bus_req_q;
  assign bus_cmd   = xfer_q.cmd;
  assign bus_addr  = xfer_q.addr;
  assign bus_wdata = xfer_q.wdata;
  assign err       = err_q;
  assign err_src   = err_src_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: the bench plays both requesters and the bus
// slave, with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [3:0]  C_NONE = 4'h0;
  localparam logic [3:0]  C_LW   = 4'h2;
  localparam logic [3:0]  C_SW   = 4'hA;
  localparam logic [31:0] C_NOOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_ack;
  logic [3:0]  dm_cmd;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_ack;
  logic        bus_req;
  logic [3:0]  bus_cmd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic        err_src;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (64),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_inst   (if_inst),
    .if_ack    (if_ack),
    .dm_cmd    (dm_cmd),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_dout   (dm_dout),
    .dm_ack    (dm_ack),
    .bus_req   (bus_req),
    .bus_cmd   (bus_cmd),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err),
    .err_src   (err_src)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next grant.
  task automatic wait_grant(input string tag);
    for (int k = 0; k < 20 && !bus_req; k++) step();
    check(tag, 32'(bus_req), 32'd1);
  endtask

  logic [31:0] starve_addr [6];
  int          di;
  int          early_err;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_cmd = C_NONE; dm_addr = '0;
    dm_din = '0; bus_rdata = '0; bus_ack = 1'b0;
    step(); step();

    // ---- reset state
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_cmd", 32'(bus_cmd), 32'(C_NONE));
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_if_inst", if_inst, C_NOOP);
    check("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    check("rst_err", {30'b0, err, err_src}, 32'd0);
    #3 rst = 1'b1;
    step();

    // ---- bus_ack while IDLE is ignored
    bus_ack = 1'b1; #1;
    check("idle_ack_ignored", {30'b0, if_ack, dm_ack}, 32'd0);
    step(); bus_ack = 1'b0;
    check("idle_no_grant", 32'(bus_req), 32'd0);

    // ---- fetch only, ack 3 cycles after bus_req
    if_req = 1'b1; if_addr = 32'h100; #1;
    check("fetch_stall_pre", 32'(stall_if), 32'd1);
    step();
    check("fetch_bus_req", 32'(bus_req), 32'd1);
    check("fetch_bus_addr", bus_addr, 32'h100);
    check("fetch_bus_cmd", 32'(bus_cmd), 32'(C_LW));
    step(); step();
    check("fetch_wait_stall", {30'b0, stall_if, if_ack}, 32'd2);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0050_0093; #1;
    check("fetch_if_ack", 32'(if_ack), 32'd1);
    check("fetch_if_inst", if_inst, 32'h0050_0093);
    check("fetch_stall_low", 32'(stall_if), 32'd0);
    step(); bus_ack = 1'b0; if_req = 1'b0; #1;
    check("fetch_done_idle", {30'b0, bus_req, if_ack}, 32'd0);
    step();

    // ---- contention: data wins, then fetch after one IDLE cycle
    if_req = 1'b1; if_addr = 32'h104; dm_cmd = C_LW; dm_addr = 32'h2000;
    step();
    check("cont_first_addr", bus_addr, 32'h2000);
    check("cont_stall_if", 32'(stall_if), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222; #1;
    check("cont_dm_ack", {30'b0, dm_ack, if_ack}, 32'd2);
    check("cont_dm_dout", dm_dout, 32'h1111_2222);
    step(); bus_ack = 1'b0; dm_cmd = C_NONE; #1;
    check("cont_idle_bubble", 32'(bus_req), 32'd0);
    step();
    check("cont_fetch_grant", {31'b0, bus_req}, 32'd1);
    check("cont_fetch_addr", bus_addr, 32'h104);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0022; #1;
    check("cont_if_ack", {30'b0, if_ack, dm_ack}, 32'd2);
    step(); bus_ack = 1'b0; if_req = 1'b0;
    step();

    // ---- starvation: 4 data grants, forced fetch, data resumes
    starve_addr[0] = 32'h3000; starve_addr[1] = 32'h3004; starve_addr[2] = 32'h3008;
    starve_addr[3] = 32'h300C; starve_addr[4] = 32'h0200; starve_addr[5] = 32'h3010;
    di = 0;
    if_req = 1'b1; if_addr = 32'h200; dm_cmd = C_LW; dm_addr = 32'h3000;
    for (int g = 0; g < 6; g++) begin
      wait_grant($sformatf("starve_grant%0d", g));
      check($sformatf("starve_addr%0d", g), bus_addr, starve_addr[g]);
      bus_ack = 1'b1; bus_rdata = 32'hA000_0000 + 32'(g); #1;
      check($sformatf("starve_acks%0d", g), {30'b0, if_ack, dm_ack},
            (g == 4) ? 32'd2 : 32'd1);
      step(); bus_ack = 1'b0;
      if (g != 4) begin
        di++;
        dm_addr = 32'h3000 + 32'(4 * di);
        if (di == 5) begin
          dm_cmd = C_NONE;
          if_req = 1'b0;
        end
      end
    end
    step();

    // ---- store: latched values held despite input changes
    dm_cmd = C_SW; dm_addr = 32'h3004; dm_din = 32'hDEAD_BEEF;
    step();
    check("st_cmd", 32'(bus_cmd), 32'(C_SW));
    check("st_wdata", bus_wdata, 32'hDEAD_BEEF);
    dm_din = 32'h0; dm_addr = 32'hFFFF_0000;
    step(); step();
    check("st_wdata_hold", bus_wdata, 32'hDEAD_BEEF);
    check("st_addr_hold", bus_addr, 32'h3004);
    check("st_stall_mem", 32'(stall_mem), 32'd1);
    bus_ack = 1'b1; #1;
    check("st_dm_ack", {30'b0, dm_ack, stall_mem}, 32'd2);
    step(); bus_ack = 1'b0; dm_cmd = C_NONE; #1;
    check("st_after", {29'b0, dm_ack, stall_mem, bus_req}, 32'd0);
    step();

    // ---- timeout on a data load
    dm_cmd = C_LW; dm_addr = 32'h4000;
    step();
    check("to_grant", 32'(bus_req), 32'd1);
    early_err = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      early_err += int'(err);
    end
    check("to_no_early_err", 32'(early_err), 32'd0);
    check("to_still_req", 32'(bus_req), 32'd1);
    step();
    check("to_err", {30'b0, err, err_src}, 32'd3);
    check("to_dm_ack", {30'b0, dm_ack, bus_req}, 32'd2);
    check("to_dm_dout", dm_dout, 32'h0);
    dm_cmd = C_NONE;
    step();
    check("to_err_pulse", {29'b0, err, err_src, dm_ack}, 32'd2);
    check("to_no_regrant", 32'(bus_req), 32'd0);

    // ---- async reset mid-fetch
    if_req = 1'b1; if_addr = 32'h500;
    step();
    check("ar_grant", 32'(bus_req), 32'd1);
    #3 rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678; #1;
    check("ar_bus_req_drop", 32'(bus_req), 32'd0);
    check("ar_no_if_ack", {31'b0, if_ack}, 32'd0);
    check("ar_err_src_clr", 32'(err_src), 32'd0);
    #1 rst = 1'b1; bus_ack = 1'b0;
    step();
    check("ar_regrant_addr", bus_addr, 32'h500);
    check("ar_regrant_req", {28'b0, bus_cmd}, 32'(C_LW));
    bus_ack = 1'b1; bus_rdata = 32'h0000_0513; #1;
    check("ar_if_inst", if_inst, 32'h0000_0513);
    step(); bus_ack = 1'b0; if_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got stuck expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
